// File: rtl/bldc_pwm_pkg.sv
// Shared definitions for the BLDC bridge PWM: channel FSM state encoding and
// dead-time range limits used to clamp the DEADTIME parameter.
package bldc_pwm_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2,
        ST_DEAD = 2'd3
    } ch_state_e;

    localparam int DEADTIME_MIN = 1;
    localparam int DEADTIME_MAX = 255;
    localparam int DCNT_W       = 8;

    // Out-of-range dead-times are pulled to the nearest legal value so the
    // interlock can never be configured to zero gap.
    function automatic int dt_clamp(input int dt);
        if (dt < DEADTIME_MIN) begin
            return DEADTIME_MIN;
        end
        if (dt > DEADTIME_MAX) begin
            return DEADTIME_MAX;
        end
        return dt;
    endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// One bridge leg: turns the registered raw PWM into complementary high/low gate
// drives with a dead-time gap on every transition and a force-off override.
module pwm_deadtime
    import bldc_pwm_pkg::*;
#(
    parameter int DEADTIME = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic force_off,
    input  logic raw_q,
    output logic PH,
    output logic PL
);

    localparam logic [DCNT_W-1:0] DT_RELOAD = DCNT_W'(dt_clamp(DEADTIME) - 1);

    ch_state_e         state_q, state_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic              target_q, target_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_OFF;
            dcnt_q   <= '0;
            target_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dcnt_q   <= dcnt_d;
            target_q <= target_d;
        end
    end

    // Any change of raw while waiting restarts the full gap, so a gate only
    // turns on after raw has been stable for the whole dead-time.
    always_comb begin
        state_d  = state_q;
        dcnt_d   = dcnt_q;
        target_d = target_q;
        if (force_off) begin
            state_d = ST_OFF;
        end else begin
            unique case (state_q)
                ST_OFF: begin
                    state_d  = ST_DEAD;
                    target_d = raw_q;
                    dcnt_d   = DT_RELOAD;
                end
                ST_HI: begin
                    if (!raw_q) begin
                        state_d  = ST_DEAD;
                        target_d = raw_q;
                        dcnt_d   = DT_RELOAD;
                    end
                end
                ST_LO: begin
                    if (raw_q) begin
                        state_d  = ST_DEAD;
                        target_d = raw_q;
                        dcnt_d   = DT_RELOAD;
                    end
                end
                ST_DEAD: begin
                    if (raw_q != target_q) begin
                        target_d = raw_q;
                        dcnt_d   = DT_RELOAD;
                    end else if (dcnt_q == '0) begin
                        state_d = target_q ? ST_HI : ST_LO;
                    end else begin
                        dcnt_d = dcnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                end
            endcase
        end
    end

    assign PH = (state_q == ST_HI);
    assign PL = (state_q == ST_LO);

endmodule

// File: rtl/pwm_bridge.sv
// Multi-channel BLDC bridge PWM with double-buffered duty and dead-time legs.
// Define PWM_CENTER_EN for an up/down (center-aligned) counter; default is sawtooth.
module pwm_bridge
    import bldc_pwm_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 3,
    parameter int DEADTIME = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      E,
    input  logic [CHANNELS-1:0]       F,
    input  logic                      LD,
    input  logic [CHANNELS*WIDTH-1:0] D,
    output logic [CHANNELS-1:0]       PH,
    output logic [CHANNELS-1:0]       PL,
    output logic                      X
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0]          cnt_q, cnt_d;
    logic                      x_q, x_d;
    logic [CHANNELS*WIDTH-1:0] shadow_q, shadow_d;
    logic                      pending_q, pending_d;
    logic [CHANNELS*WIDTH-1:0] duty_act_q, duty_act_d;
    logic [CHANNELS-1:0]       raw_q, raw_d;
    logic                      boundary;

`ifdef PWM_CENTER_EN
    logic dir_down_q, dir_down_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            dir_down_q <= 1'b0;
        end else begin
            dir_down_q <= dir_down_d;
        end
    end

    // Triangle counter: the turnaround values are visited once per sweep, and
    // the valley boundary is the last down-count step before reaching zero.
    always_comb begin
        cnt_d      = cnt_q;
        dir_down_d = dir_down_q;
        if (!dir_down_q) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d      = cnt_q - 1'b1;
                dir_down_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            if (cnt_q == '0) begin
                cnt_d      = WIDTH'(1);
                dir_down_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    assign boundary = dir_down_q && (cnt_q == WIDTH'(1));
`else
    always_comb begin
        cnt_d = cnt_q + 1'b1;
    end

    assign boundary = (cnt_q == CNT_MAX);
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q      <= '0;
            x_q        <= 1'b0;
            shadow_q   <= '0;
            pending_q  <= 1'b0;
            duty_act_q <= '0;
            raw_q      <= '0;
        end else begin
            cnt_q      <= cnt_d;
            x_q        <= x_d;
            shadow_q   <= shadow_d;
            pending_q  <= pending_d;
            duty_act_q <= duty_act_d;
            raw_q      <= raw_d;
        end
    end

    // A strobe landing on the boundary cycle bypasses the shadow so the
    // freshest duty word is the one that takes effect.
    always_comb begin
        x_d        = boundary;
        shadow_d   = LD ? D : shadow_q;
        pending_d  = pending_q | LD;
        duty_act_d = duty_act_q;
        if (boundary) begin
            pending_d = 1'b0;
            if (LD) begin
                duty_act_d = D;
            end else if (pending_q) begin
                duty_act_d = shadow_q;
            end
        end
    end

    always_comb begin
        raw_d = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            raw_d[k] = (cnt_q < duty_act_q[k*WIDTH +: WIDTH]);
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_leg
        pwm_deadtime #(
            .DEADTIME (DEADTIME)
        ) u_deadtime (
            .CLK       (CLK),
            .RST       (RST),
            .force_off (~E | F[k]),
            .raw_q     (raw_q[k]),
            .PH        (PH[k]),
            .PL        (PL[k])
        );
    end

    assign X = x_q;

endmodule

// File: tb/tb_pwm_bridge.sv
// Directed bench for pwm_bridge (WIDTH=4, CHANNELS=3, DEADTIME=2), sawtooth mode;
// expected pulse widths and positions are hand-computed per 16-cycle period.
module tb_pwm_bridge;

    localparam int WIDTH    = 4;
    localparam int CHANNELS = 3;
    localparam int DEADTIME = 2;

    logic                      CLK = 1'b0;
    logic                      RST;
    logic                      E;
    logic [CHANNELS-1:0]       F;
    logic                      LD;
    logic [CHANNELS*WIDTH-1:0] D;
    logic [CHANNELS-1:0]       PH;
    logic [CHANNELS-1:0]       PL;
    logic                      X;

    int checks  = 0;
    int errors  = 0;
    int overlap = 0;
    int ph_n[CHANNELS];
    int pl_n[CHANNELS];
    int ph_first[CHANNELS];
    int x_n;

    typedef struct {
        logic [3:0] d0;
        int         ph0;
        int         pl0;
    } vec_t;

    vec_t vecs[5];

    pwm_bridge #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .DEADTIME (DEADTIME)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .E   (E),
        .F   (F),
        .LD  (LD),
        .D   (D),
        .PH  (PH),
        .PL  (PL),
        .X   (X)
    );

    always #5 CLK = ~CLK;

    // Both gates of a leg must never be on together, in any cycle.
    always @(negedge CLK) begin
        if (RST === 1'b0 && (PH & PL) != '0) begin
            overlap++;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Called at a negedge; strobes LD for exactly one rising edge.
    task automatic applyStimulus(input logic [3:0] d0);
        D  = {4'd12, 4'd8, d0};
        LD = 1'b1;
        @(negedge CLK);
        LD = 1'b0;
    endtask

    task automatic waitX();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            LD = 1'b0;
            if (X === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            checkOutput("x_timeout", 0, 1);
        end
    endtask

    // Samples one full period starting at the X cycle (cnt==0); optionally
    // strobes LD so that it is sampled at the edge ending cnt==ld_at.
    task automatic measurePeriod(input int ld_at, input logic [3:0] ld_d0);
        waitX();
        x_n = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            ph_n[k]     = 0;
            pl_n[k]     = 0;
            ph_first[k] = -1;
        end
        for (int i = 0; i < 16; i++) begin
            if (i > 0) begin
                @(negedge CLK);
            end
            if (X === 1'b1) begin
                x_n++;
            end
            for (int k = 0; k < CHANNELS; k++) begin
                if (PH[k] === 1'b1) begin
                    if (ph_first[k] < 0) begin
                        ph_first[k] = i;
                    end
                    ph_n[k]++;
                end
                if (PL[k] === 1'b1) begin
                    pl_n[k]++;
                end
            end
            if (i == ld_at) begin
                D  = {4'd12, 4'd8, ld_d0};
                LD = 1'b1;
            end else begin
                LD = 1'b0;
            end
        end
    endtask

    initial begin
        vecs[0] = '{4'd1,  0,  13};
        vecs[1] = '{4'd2,  0,  12};
        vecs[2] = '{4'd0,  0,  16};
        vecs[3] = '{4'd15, 13, 0};
        vecs[4] = '{4'd4,  2,  10};

        RST = 1'b1;
        E   = 1'b0;
        F   = '0;
        LD  = 1'b0;
        D   = '0;
        repeat (2) @(negedge CLK);
        checkOutput("rst_ph", int'(PH), 0);
        checkOutput("rst_pl", int'(PL), 0);
        checkOutput("rst_x", int'(X), 0);

        RST = 1'b0;
        @(negedge CLK);
        checkOutput("post_rst_x", int'(X), 0);
        checkOutput("e_off_pl", int'(PL), 0);

        // First load: D = {12, 8, 4}, checked in the first period after X.
        E = 1'b1;
        applyStimulus(4'd4);
        measurePeriod(-1, 4'd0);
        checkOutput("first_x_width", x_n, 1);
        checkOutput("d4_ph0", ph_n[0], 2);
        checkOutput("d4_ph0_start", ph_first[0], 4);
        checkOutput("d4_pl0", pl_n[0], 10);
        checkOutput("d4_dead0", 16 - ph_n[0] - pl_n[0], 4);
        checkOutput("d8_ph1", ph_n[1], 6);
        checkOutput("d8_pl1", pl_n[1], 6);
        checkOutput("d12_ph2", ph_n[2], 10);
        checkOutput("d12_pl2", pl_n[2], 2);

        foreach (vecs[v]) begin
            applyStimulus(vecs[v].d0);
            measurePeriod(-1, 4'd0);
            measurePeriod(-1, 4'd0);
            checkOutput($sformatf("vec%0d_ph0", v), ph_n[0], vecs[v].ph0);
            checkOutput($sformatf("vec%0d_pl0", v), pl_n[0], vecs[v].pl0);
        end
        checkOutput("d4_again_start", ph_first[0], 4);

        // Mid-period load must not disturb the running period.
        measurePeriod(5, 4'd8);
        checkOutput("ld_mid_ph0", ph_n[0], 2);
        checkOutput("ld_mid_pl0", pl_n[0], 10);
        measurePeriod(15, 4'd4);
        checkOutput("ld_new_ph0", ph_n[0], 6);
        checkOutput("ld_new_pl0", pl_n[0], 6);
        checkOutput("ld_new_start", ph_first[0], 4);
        measurePeriod(-1, 4'd0);
        checkOutput("ld_bnd_ph0", ph_n[0], 2);
        checkOutput("ld_bnd_pl0", pl_n[0], 10);

        // Float leg 1 while its high side is on, then release it.
        waitX();
        repeat (6) @(negedge CLK);
        checkOutput("flt_pre_ph1", int'(PH[1]), 1);
        F = 3'b010;
        @(negedge CLK);
        checkOutput("flt_ph1", int'(PH[1]), 0);
        checkOutput("flt_pl1", int'(PL[1]), 0);
        checkOutput("flt_ph2", int'(PH[2]), 1);
        @(negedge CLK);
        checkOutput("flt_pl0", int'(PL[0]), 1);
        repeat (2) @(negedge CLK);
        F = 3'b000;
        @(negedge CLK);
        checkOutput("rel1_ph1", int'(PH[1]), 0);
        checkOutput("rel1_pl1", int'(PL[1]), 0);
        @(negedge CLK);
        checkOutput("rel2_ph1", int'(PH[1]), 0);
        checkOutput("rel2_pl1", int'(PL[1]), 0);
        @(negedge CLK);
        checkOutput("rel3_pl1", int'(PL[1]), 1);
        checkOutput("rel3_ph1", int'(PH[1]), 0);
        checkOutput("rel3_pl0", int'(PL[0]), 1);
        checkOutput("rel3_ph2", int'(PH[2]), 1);

        // Reset while PH[0] is on, with a load still pending.
        waitX();
        D  = {4'd12, 4'd8, 4'd9};
        LD = 1'b1;
        @(negedge CLK);
        LD = 1'b0;
        repeat (4) @(negedge CLK);
        checkOutput("pre_rst_ph0", int'(PH[0]), 1);
        RST = 1'b1;
        @(negedge CLK);
        checkOutput("mid_rst_ph", int'(PH), 0);
        checkOutput("mid_rst_pl", int'(PL), 0);
        checkOutput("mid_rst_x", int'(X), 0);
        RST = 1'b0;
        measurePeriod(-1, 4'd0);
        measurePeriod(-1, 4'd0);
        checkOutput("post_rst_ph0", ph_n[0], 0);
        checkOutput("post_rst_pl0", pl_n[0], 16);
        checkOutput("post_rst_pl1", pl_n[1], 16);
        checkOutput("post_rst_ph2", ph_n[2], 0);

        checkOutput("ph_pl_overlap", overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_bridge.md
Name: pwm_bridge

Overview:
Parametrised multi-channel PWM generator for the BLDC inverter bridge. It is the successor to the single-channel 4-bit pwm block, and adds:
- N channels, each with complementary high/low gate outputs
- a programmable dead-time interlock
- double-buffered duty loading at the period boundary
- a per-channel float control for six-step commutation
It sits between the commutation/speed logic and the gate-driver pins.

Parameters:
WIDTH, 8, duty/counter resolution in bits; edge-aligned period = 2^WIDTH cycles
CHANNELS, 3, number of bridge legs
DEADTIME, 4, dead-time in CLK cycles inserted on every output transition; legal range 1..255

Ports:
CLK  input  1  system clock; all logic on rising edge
RST  input  1  synchronous reset, active-high
E    input  1  global enable; 0 forces all gates off
F    input  CHANNELS  per-channel float; 1 forces that leg's PH=PL=0
LD   input  1  duty load strobe; captures D into shadow registers
D    input  CHANNELS*WIDTH  duty words, channel k at bits [k*WIDTH +: WIDTH]
PH   output CHANNELS  high-side gate drive
PL   output CHANNELS  low-side gate drive
X    output 1  period-start pulse, one cycle wide

Behaviour:
- Interface decision: one clock CLK; reset RST is synchronous and active-high.
- Reset values: cnt=0, shadow=0, duty_act=0, pending=0, raw_q=0, X=0, all channel FSMs in OFF, PH=PL=0.
- Counter: cnt runs 0..2^WIDTH-1 and wraps. It runs regardless of E and F.
- X is registered: X <= (cnt == 2^WIDTH-1). X is therefore high in each cycle where cnt==0, except the first cycle after reset.
- Duty loading:
  - LD=1 sets shadow <= D and pending <= 1.
  - In the cycle cnt==2^WIDTH-1 with pending=1: duty_act <= shadow and pending <= 0.
  - If LD coincides with that boundary cycle, the new D is applied.
  - Multiple LDs within one period: last one wins.
- Raw PWM: raw_q[k] <= (cnt < duty_act[k]), registered (1-cycle latency).
  - duty 0 gives a permanently low raw signal.
  - duty 2^WIDTH-1 gives raw high for all but one cycle.
- Channel FSM, one per channel, states OFF, HI, LO, DEAD (with dcnt and target):
  - force = ~E | F[k]; when force=1 the next state is OFF from any state (highest priority).
  - OFF with force=0: go to DEAD, target=raw_q, dcnt=DEADTIME-1.
  - HI with raw_q=0, or LO with raw_q=1: go to DEAD, target=raw_q, dcnt=DEADTIME-1.
  - DEAD with raw_q!=target: target=raw_q, dcnt reloaded to DEADTIME-1, stay in DEAD.
  - DEAD with dcnt==0: go to HI if target=1, else LO.
  - DEAD otherwise: dcnt decrements.
- Outputs: PH = (state==HI), PL = (state==LO), decoded from registered state. PH&PL is never 1.
- Resulting widths in steady state: PH = D-DEADTIME cycles, PL = 2^WIDTH-D-DEADTIME cycles.
  - Pulses with D<=DEADTIME never assert PH.
  - D==0 holds PL continuously.
- Reset mid-period: everything returns to reset values on the next edge; the shadow and a pending load are discarded.

Optional Feature:
PWM_CENTER_EN
- Defined: cnt counts up/down 0..2^WIDTH-1..0, giving a period of 2*(2^WIDTH-1) cycles.
  - raw = cnt < duty_act.
  - Shadow transfer and X occur at the valley, i.e. the cycle before cnt returns to 0.
  - A direction register is added, reset to up.
- Undefined: edge-aligned sawtooth as above, with no direction register.

Decomposition:
- Package bldc_pwm_pkg holds:
  - the FSM state encoding constants (ST_OFF, ST_HI, ST_LO, ST_DEAD)
  - the DEADTIME range-check constants
- Sub-module pwm_deadtime: one channel FSM, with inputs CLK, RST, force, raw_q and outputs PH, PL. It is generated CHANNELS times.
- Counter, shadow/pending and X logic stay in the top level.

Test Plan:
- Bench configuration: WIDTH=4, CHANNELS=3, DEADTIME=2.
- D0=4, LD, E=1: after the first X, PH[0] is high 2 cycles, starting DEADTIME+2=4 cycles after X. PL[0] is high 10 cycles per 16-cycle period. The DEAD gaps are exactly 2 cycles each.
- D0=1 and D0=2: PH[0] never asserts. PL[0] drops for 3 and 4 cycles respectively per period.
- D0=0: PL[0] is constantly 1 and PH[0] is constantly 0. D0=15: PH[0] is high 13 cycles and PL[0] is never asserted.
- LD with D0=8 pulsed at cnt=5: waveform is unchanged until the next cnt==0. LD coinciding with cnt==15 takes effect at that next cnt==0.
- F=3'b010 mid-period: PH[1]=PL[1]=0 on the next edge. On F release, both stay 0 for DEADTIME cycles, then the correct side asserts. Legs 0 and 2 are unaffected.
- RST asserted while PH is high: all outputs are 0 next edge and X=0. A load pending at reset is discarded, so duty_act=0 afterwards. Every cycle is checked for PH&PL==0.
